// File: rtl/sdram_wr_buffer.sv
// ----------------------------------------------------------------------------
// sdram_wr_buffer
//
// Write-side front end of the SDRAM subsystem. Source words are collected in a
// first-word-fall-through FIFO. Once a full burst is buffered, a write request
// is raised towards the SDRAM top together with a linear frame address. The
// SDRAM top pops one word per written beat and acknowledges the burst.
//
// Ports:
//   S_CLK        system clock (only clock domain)
//   RST          synchronous active-high reset
//   frame_start  one-cycle pulse: restart the frame at address 0, flush FIFO
//   pix_valid    source word valid
//   pix_data     source word
//   pix_ready    FIFO not full
//   write_req    burst write request, held until write_ack
//   sdram_addr   burst start address, stable while write_req is high
//   sdram_data   FIFO head word (0 while empty)
//   fifo_rd_req  pop strobe, one per written word
//   write_ack    burst complete pulse
//   fifo_level   current FIFO word count
//   frame_done   one-cycle pulse when the last burst of a frame is acked
//   overflow     sticky: a push was dropped because the FIFO was full
//   underrun     sticky: a pop strobe could not be honoured
// ----------------------------------------------------------------------------
module sdram_wr_buffer #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 20,
    parameter int BURST_LEN   = 8,
    parameter int FIFO_DEPTH  = 32,
    parameter int FRAME_WORDS = 76800
) (
    input  logic                          S_CLK,
    input  logic                          RST,
    input  logic                          frame_start,
    input  logic                          pix_valid,
    input  logic [DATA_W-1:0]             pix_data,
    output logic                          pix_ready,
    output logic                          write_req,
    output logic [ADDR_W-1:0]             sdram_addr,
    output logic [DATA_W-1:0]             sdram_data,
    input  logic                          fifo_rd_req,
    input  logic                          write_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_done,
    output logic                          overflow,
    output logic                          underrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(BURST_LEN) + 1;

    localparam logic [PTR_W:0]   DEPTH_C      = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   BURST_LVL_C  = (PTR_W + 1)'(BURST_LEN);
    localparam logic [CNT_W-1:0] BURST_CNT_C  = CNT_W'(BURST_LEN);
    localparam logic [ADDR_W:0]  BURST_ADDR_C = (ADDR_W + 1)'(BURST_LEN);
    localparam logic [ADDR_W:0]  FRAME_C      = (ADDR_W + 1)'(FRAME_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_BURST    = 2'd2,
        ST_WAIT_ACK = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      pop_cnt_q, pop_cnt_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  write_req_q, write_req_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overflow_q, overflow_d;
    logic                  underrun_q, underrun_d;

    logic [PTR_W:0]        level_s;
    logic                  empty_s;
    logic                  full_s;
    logic                  burst_act_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  ack_s;
    logic                  flush_s;
    logic [PTR_W-1:0]      wr_idx_s;
    logic [CNT_W-1:0]      pop_cnt_inc_s;
    logic [ADDR_W:0]       addr_sum_s;

    // The extra pointer MSB makes the difference a true word count (0..DEPTH).
    assign level_s     = wr_ptr_q - rd_ptr_q;
    assign empty_s     = (level_s == {(PTR_W + 1){1'b0}});
    assign full_s      = (level_s == DEPTH_C);
    assign burst_act_s = (state_q == ST_REQ) || (state_q == ST_BURST);

    // A pop is honoured only while a burst is open and still short of its length.
    assign pop_s  = fifo_rd_req && !empty_s && burst_act_s && (pop_cnt_q < BURST_CNT_C);
    // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
    assign push_s = pix_valid && (!full_s || pop_s);
    assign ack_s  = (state_q == ST_WAIT_ACK) && write_ack;

    // Flush immediately in IDLE, otherwise on the ack edge that returns to IDLE.
    assign flush_s = ((state_q == ST_IDLE) && frame_start)
                   || (ack_s && (flush_pend_q || frame_start));

    // On a flush the incoming word becomes the first word of the new frame.
    assign wr_idx_s      = flush_s ? {PTR_W{1'b0}} : wr_ptr_q[PTR_W-1:0];
    assign pop_cnt_inc_s = pop_cnt_q + CNT_W'(1);
    assign addr_sum_s    = {1'b0, wr_addr_q} + BURST_ADDR_C;

    // FIFO pointer next-state: flush restarts both pointers, else push/pop steps.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush_s) begin
            rd_ptr_d = {(PTR_W + 1){1'b0}};
            wr_ptr_d = push_s ? (PTR_W + 1)'(1) : {(PTR_W + 1){1'b0}};
        end else begin
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
        end
    end

    // Burst FSM next-state, address generation and status flags.
    always_comb begin
        state_d      = state_q;
        pop_cnt_d    = pop_cnt_q;
        wr_addr_d    = wr_addr_q;
        flush_pend_d = flush_pend_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q | (pix_valid && !push_s);
        underrun_d   = underrun_q | (fifo_rd_req && !pop_s);

        case (state_q)
            ST_IDLE: begin
                pop_cnt_d    = {CNT_W{1'b0}};
                flush_pend_d = 1'b0;
                if (frame_start) begin
                    wr_addr_d = {ADDR_W{1'b0}};
                    state_d   = ST_IDLE;
                end else if (level_s >= BURST_LVL_C) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ, ST_BURST: begin
                if (frame_start) begin
                    flush_pend_d = 1'b1;
                end else begin
                    flush_pend_d = flush_pend_q;
                end
                if (pop_s) begin
                    pop_cnt_d = pop_cnt_inc_s;
                    if (pop_cnt_inc_s == BURST_CNT_C) begin
                        state_d = ST_WAIT_ACK;
                    end else begin
                        state_d = ST_BURST;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT_ACK: begin
                if (write_ack) begin
                    state_d      = ST_IDLE;
                    flush_pend_d = 1'b0;
                    // Advance first; a pending restart then overrides to 0.
                    if (addr_sum_s >= FRAME_C) begin
                        wr_addr_d    = {ADDR_W{1'b0}};
                        frame_done_d = 1'b1;
                    end else begin
                        wr_addr_d = addr_sum_s[ADDR_W-1:0];
                    end
                    if (flush_pend_q || frame_start) begin
                        wr_addr_d = {ADDR_W{1'b0}};
                    end else begin
                        wr_addr_d = wr_addr_d;
                    end
                end else begin
                    state_d = ST_WAIT_ACK;
                    if (frame_start) begin
                        flush_pend_d = 1'b1;
                    end else begin
                        flush_pend_d = flush_pend_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        write_req_d = (state_d != ST_IDLE);
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge S_CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= {(PTR_W + 1){1'b0}};
            rd_ptr_q     <= {(PTR_W + 1){1'b0}};
            pop_cnt_q    <= {CNT_W{1'b0}};
            wr_addr_q    <= {ADDR_W{1'b0}};
            flush_pend_q <= 1'b0;
            write_req_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pop_cnt_q    <= pop_cnt_d;
            wr_addr_q    <= wr_addr_d;
            flush_pend_q <= flush_pend_d;
            write_req_q  <= write_req_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            underrun_q   <= underrun_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge S_CLK) begin
        if (!RST && push_s) begin
            mem_q[wr_idx_s] <= pix_data;
        end
    end

    assign pix_ready  = !full_s;
    assign fifo_level = level_s;
    assign sdram_data = empty_s ? {DATA_W{1'b0}} : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign sdram_addr = wr_addr_q;
    assign write_req  = write_req_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign underrun   = underrun_q;

endmodule
